freq_step_ctrl: RTL and testbench
=================================

// Module: freq_step_ctrl
// PURPOSE
//  Turns debounced up/down button levels into a bounded frequency-step index, with optional auto-repeat.
//  Drives the clock divider's terminal count N, changing it only at a divider wrap point so slow_clk
//  never gets a runt pulse. Sits between the debouncers and the clock divider inside the throttle path.
// PARAMETERS
//  NUM_STEPS   6      number of steps; step_idx runs 0..NUM_STEPS-1
//  INIT_STEP   0      step loaded at reset
//  MAX_N       32     divider N at step 0; N = MAX_N >> step_idx; require MAX_N >= 2**(NUM_STEPS-1)
//  DIV_W       8      width of div_n; must hold MAX_N
//  REPEAT_CYC  25000000  hold cycles per auto-repeat step; 0 disables auto-repeat
//  WRAP_TMO    1048575   max cycles to wait for div_wrap before forcing the load; must be >= 1
// PORTS
//  CLK_50     in   1      system clock, 50 MHz
//  reset      in   1      asynchronous, active-low; all state returns to reset values at once
//  up_lvl     in   1      debounced up-button level, synchronous to CLK_50
//  dn_lvl     in   1      debounced down-button level, synchronous to CLK_50
//  div_wrap   in   1      1-cycle pulse from divider when its counter restarts (safe update point)
//  div_n      out  DIV_W  terminal count applied to the divider
//  div_load   out  1      1-cycle strobe: div_n changed this cycle
//  step_idx   out  3      current committed step
//  busy       out  1      1 while a step change is pending (WAIT_WRAP or LOAD)
//  limit_hit  out  1      1-cycle pulse: a request was refused at a bound
// BEHAVIOUR
//  Reset values: step_idx=INIT_STEP, div_n=MAX_N>>INIT_STEP, div_load=0, busy=0, limit_hit=0.
//  Also cleared at reset: FSM=IDLE, edge registers, repeat counter, timeout counter.
//  Request generation, evaluated every cycle:
//  - Exactly one level high: a rising edge (lvl & ~lvl_q) is a request in that direction.
//  - While that level stays high: repeat counter counts; on reaching REPEAT_CYC it issues another
//    request and restarts at 0. The counter is cleared whenever not exactly one level is high.
//  - Both levels high, or neither: no request; repeat counter held at 0.
//  FSM, states IDLE / WAIT_WRAP / LOAD:
//  - IDLE, request at a bound (up at NUM_STEPS-1, down at 0): limit_hit=1 next cycle;
//    stay IDLE; no load.
//  - IDLE, any other request: latch nxt=step_idx+/-1; go WAIT_WRAP; busy=1; clear timeout counter.
//  - WAIT_WRAP: div_wrap=1 sampled, or timeout counter reaches WRAP_TMO -> go LOAD.
//    Otherwise the timeout counter increments.
//  - LOAD, single cycle: step_idx<=nxt, div_n<=MAX_N>>nxt, div_load=1 for this cycle only;
//    then IDLE, busy=0.
//  - Requests arriving in WAIT_WRAP or LOAD are dropped: no queueing, no limit_hit.
//    The repeat counter keeps running during these states.
//  Latency:
//  - Rising edge sampled at cycle t -> busy=1 at t+1.
//  - div_wrap sampled at cycle w, state WAIT_WRAP -> LOAD at w+1; div_n/step_idx/div_load
//    valid from w+1.
//  - div_wrap in the same cycle as the request is not used; the next wrap is awaited.
//  Arithmetic:
//  - step_idx saturates and never wraps.
//  - div_n is a logical right shift, zero-extended to DIV_W; never 0 given the parameter rule.
//  Reset mid-operation: a pending change is discarded; outputs return to reset values immediately.
// TESTING (bench params: MAX_N=32, NUM_STEPS=6, REPEAT_CYC=4, WRAP_TMO=20)
//  1 Assert reset low mid-run -> step_idx=0, div_n=32, busy=0, div_load=0 within the same cycle.
//  2 up_lvl 0->1 at t, div_wrap pulse at t+5 -> busy 1 from t+1; at t+6 step_idx=1, div_n=16,
//    div_load=1 for one cycle.
//  3 step_idx=5, up press -> limit_hit one cycle, div_load never asserts, div_n stays 1.
//  4 up_lvl and dn_lvl rise together and hold 20 cycles -> no request, step_idx unchanged.
//  5 Hold up_lvl, div_wrap every 2 cycles -> steps 0->1->2->3 at roughly 4-cycle spacing;
//    div_n 32,16,8,4.
//  6 Up press, no div_wrap -> forced LOAD after 20 WAIT_WRAP cycles; div_n=16.
//    Repeat, then drop reset low in WAIT_WRAP -> no load, step_idx=0.

Source files
------------

// File: rtl/freq_step_ctrl.sv
// freq_step_ctrl: converts debounced up/down levels into a bounded step index
// and hands the clock divider a new terminal count only at a divider wrap point.
module freq_step_ctrl #(
  parameter int NUM_STEPS  = 6,
  parameter int INIT_STEP  = 0,
  parameter int MAX_N      = 32,
  parameter int DIV_W      = 8,
  parameter int REPEAT_CYC = 25000000,
  parameter int WRAP_TMO   = 1048575
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic             up_lvl,
  input  logic             dn_lvl,
  input  logic             div_wrap,
  output logic [DIV_W-1:0] div_n,
  output logic             div_load,
  output logic [2:0]       step_idx,
  output logic             busy,
  output logic             limit_hit
);

  localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC + 1) : 1;
  localparam int TMO_W = (WRAP_TMO > 1) ? $clog2(WRAP_TMO + 1) : 1;

  localparam bit               RPT_EN   = (REPEAT_CYC > 0);
  localparam logic [RPT_W-1:0] RPT_LAST = (REPEAT_CYC > 0) ? RPT_W'(REPEAT_CYC - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WRAP_TMO - 1);
  localparam logic [2:0]       TOP_STEP = 3'(NUM_STEPS - 1);
  localparam logic [2:0]       RST_STEP = 3'(INIT_STEP);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(MAX_N >> INIT_STEP);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WRAP,
    LOAD
  } state_e;

  state_e           state_q, state_d;
  logic             up_q, dn_q;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       nxt_q, nxt_d;
  logic [2:0]       step_q, step_d;
  logic [DIV_W-1:0] div_n_q, div_n_d;
  logic             load_q, load_d;
  logic             limit_q, limit_d;

  logic one_up, one_dn, held, rpt_fire, req_up, req_dn;

  // Request generation: rising edge of a lone level, plus auto-repeat while it is held.
  always_comb begin
    one_up   = up_lvl & ~dn_lvl;
    one_dn   = dn_lvl & ~up_lvl;
    held     = (one_up & up_q) | (one_dn & dn_q);
    rpt_fire = 1'b0;
    rpt_d    = '0;
    if (held && RPT_EN) begin
      if (rpt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
    req_up = one_up & (~up_q | rpt_fire);
    req_dn = one_dn & (~dn_q | rpt_fire);
  end

  // Next-state and output computation for the step-change FSM.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    tmo_d   = tmo_q;
    step_d  = step_q;
    div_n_d = div_n_q;
    load_d  = 1'b0;
    limit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_up) begin
          if (step_q >= TOP_STEP) begin
            limit_d = 1'b1;
          end else begin
            nxt_d   = step_q + 3'd1;
            tmo_d   = '0;
            state_d = WAIT_WRAP;
          end
        end else if (req_dn) begin
          if (step_q == 3'd0) begin
            limit_d = 1'b1;
          end else begin
            nxt_d   = step_q - 3'd1;
            tmo_d   = '0;
            state_d = WAIT_WRAP;
          end
        end
      end
      WAIT_WRAP: begin
        // The commit happens on the way into LOAD so the new values are visible during LOAD.
        if (div_wrap || (tmo_q == TMO_LAST)) begin
          state_d = LOAD;
          step_d  = nxt_q;
          div_n_d = DIV_W'(MAX_N >> nxt_q);
          load_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      rpt_q   <= '0;
      tmo_q   <= '0;
      nxt_q   <= RST_STEP;
      step_q  <= RST_STEP;
      div_n_q <= RST_DIV;
      load_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_lvl;
      dn_q    <= dn_lvl;
      rpt_q   <= rpt_d;
      tmo_q   <= tmo_d;
      nxt_q   <= nxt_d;
      step_q  <= step_d;
      div_n_q <= div_n_d;
      load_q  <= load_d;
      limit_q <= limit_d;
    end
  end

  assign div_n     = div_n_q;
  assign div_load  = load_q;
  assign step_idx  = step_q;
  assign busy      = (state_q != IDLE);
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed bench for freq_step_ctrl with small repeat/timeout parameters.
module tb_freq_step_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       up    = 1'b0;
  logic       dn    = 1'b0;
  logic       wrap  = 1'b0;
  logic [7:0] div_n;
  logic       div_load;
  logic [2:0] step_idx;
  logic       busy;
  logic       limit_hit;

  int checks   = 0;
  int failures = 0;

  freq_step_ctrl #(
    .NUM_STEPS (6),
    .INIT_STEP (0),
    .MAX_N     (32),
    .DIV_W     (8),
    .REPEAT_CYC(4),
    .WRAP_TMO  (20)
  ) dut (
    .CLK_50   (clk),
    .reset    (rst_n),
    .up_lvl   (up),
    .dn_lvl   (dn),
    .div_wrap (wrap),
    .div_n    (div_n),
    .div_load (div_load),
    .step_idx (step_idx),
    .busy     (busy),
    .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete step change: press, one WAIT_WRAP cycle, wrap, LOAD, back to IDLE.
  task automatic step_once(input bit go_up, input logic [2:0] exp_step, input logic [7:0] exp_n);
    if (go_up) up = 1'b1; else dn = 1'b1;
    tick();
    check("step_busy", busy, 1);
    up   = 1'b0;
    dn   = 1'b0;
    wrap = 1'b1;
    tick();
    check("step_load", div_load, 1);
    check("step_idx", step_idx, exp_step);
    check("step_div_n", div_n, exp_n);
    wrap = 1'b0;
    tick();
    check("step_idle", busy, 0);
    check("step_load_clr", div_load, 0);
  endtask

  initial begin
    bit bad;

    // Power-on reset values
    tick();
    tick();
    check("rst_step", step_idx, 0);
    check("rst_div_n", div_n, 32);
    check("rst_busy", busy, 0);
    check("rst_load", div_load, 0);
    check("rst_limit", limit_hit, 0);
    rst_n = 1'b1;
    tick();

    // Up press, wrap arrives five cycles after the request
    up = 1'b1;
    tick();
    check("t2_busy", busy, 1);
    check("t2_step_hold", step_idx, 0);
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_wait_busy", busy, 1);
      check("t2_wait_noload", div_load, 0);
    end
    wrap = 1'b1;
    tick();
    check("t2_step", step_idx, 1);
    check("t2_div_n", div_n, 16);
    check("t2_load", div_load, 1);
    wrap = 1'b0;
    tick();
    check("t2_load_1cyc", div_load, 0);
    check("t2_idle", busy, 0);

    // Climb to the top step, then press up against the bound
    step_once(1'b1, 3'd2, 8'd8);
    step_once(1'b1, 3'd3, 8'd4);
    step_once(1'b1, 3'd4, 8'd2);
    step_once(1'b1, 3'd5, 8'd1);
    up = 1'b1;
    tick();
    check("t3_limit", limit_hit, 1);
    check("t3_busy", busy, 0);
    up  = 1'b0;
    bad = 1'b0;
    tick();
    check("t3_limit_1cyc", limit_hit, 0);
    for (int i = 0; i < 6; i++) begin
      if (div_load || busy) bad = 1'b1;
      tick();
    end
    check("t3_noload", bad, 0);
    check("t3_div_n", div_n, 1);
    check("t3_step", step_idx, 5);

    // Down direction
    step_once(1'b0, 3'd4, 8'd2);

    // Both levels together: no request
    up  = 1'b1;
    dn  = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || div_load || limit_hit) bad = 1'b1;
    end
    check("t4_no_req", bad, 0);
    check("t4_step", step_idx, 4);
    up = 1'b0;
    dn = 1'b0;
    tick();
    check("t4_release", busy, 0);

    // Reset asserted while LOAD is showing a freshly committed step
    dn = 1'b1;
    tick();
    dn   = 1'b0;
    wrap = 1'b1;
    tick();
    check("t1_pre_load", div_load, 1);
    check("t1_pre_step", step_idx, 3);
    check("t1_pre_div_n", div_n, 4);
    wrap = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t1_step", step_idx, 0);
    check("t1_div_n", div_n, 32);
    check("t1_busy", busy, 0);
    check("t1_load", div_load, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Down press at step 0 hits the lower bound
    dn = 1'b1;
    tick();
    check("lo_limit", limit_hit, 1);
    check("lo_busy", busy, 0);
    dn = 1'b0;
    tick();
    check("lo_limit_1cyc", limit_hit, 0);
    check("lo_step", step_idx, 0);

    // Held up with wrap on odd edges: loads visible after edges 1, 5, 9
    up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wrap = (k % 2 == 1);
      tick();
      if (k == 1 || k == 5 || k == 9) begin
        check("t5_load", div_load, 1);
        check("t5_step", step_idx, 3'((k + 3) / 4));
        check("t5_div_n", div_n, 32 >> ((k + 3) / 4));
      end else begin
        check("t5_noload", div_load, 0);
      end
    end
    up   = 1'b0;
    wrap = 1'b0;
    tick();
    check("t5_final_step", step_idx, 3);
    check("t5_final_div_n", div_n, 4);
    check("t5_final_busy", busy, 0);

    // No wrap at all: forced load after 20 WAIT_WRAP cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    up = 1'b1;
    tick();
    check("t6_busy", busy, 1);
    up  = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (div_load || !busy) bad = 1'b1;
    end
    check("t6_wait", bad, 0);
    tick();
    check("t6_load", div_load, 1);
    check("t6_div_n", div_n, 16);
    check("t6_step", step_idx, 1);
    tick();
    check("t6_idle", busy, 0);

    // Pending change discarded by reset during WAIT_WRAP
    up = 1'b1;
    tick();
    up = 1'b0;
    tick();
    tick();
    check("t6b_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6b_step", step_idx, 0);
    check("t6b_busy_clr", busy, 0);
    check("t6b_div_n", div_n, 32);
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (div_load) bad = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (div_load || busy) bad = 1'b1;
    end
    check("t6b_noload", bad, 0);
    check("t6b_step_end", step_idx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
